// File: rtl/rv32f_csr_responder.sv
// rv32f_csr_responder: FP CSR responder (fflags 0x001, frm 0x002, fcsr 0x003).
// Holds the rounding mode and the sticky exception flags, and ORs in the flags
// that the FP units report. Each access returns the old value through a
// one-entry response buffer.
module rv32f_csr_responder #(
    parameter logic [2:0] RESET_FRM        = 3'b000,
    parameter bit         STALL_ON_FP_BUSY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req_valid,
    output logic        csr_req_ready,
    input  logic [11:0] csr_req_addr,
    input  logic [1:0]  csr_req_op,
    input  logic [31:0] csr_req_wdata,
    output logic        csr_resp_valid,
    input  logic        csr_resp_ready,
    output logic [31:0] csr_resp_rdata,
    output logic        csr_resp_illegal,
    input  logic        fp_flags_valid,
    input  logic [4:0]  fp_flags,
    input  logic        fp_busy,
    output logic [2:0]  frm,
    output logic        frm_invalid
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    logic [4:0]  fflags_q, fflags_d;
    logic [2:0]  frm_q, frm_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_illegal_q, resp_illegal_d;

    logic [4:0]  fl_in;
    logic [4:0]  fl_cur;
    logic        is_ff, is_rm, is_cs, legal;
    logic        stall, req_ready, accept, do_wr;
    logic [7:0]  old_val, new_val, opnd;

    // Only the low byte of the operand can reach any field.
    logic unused_wdata;
    assign unused_wdata = ^csr_req_wdata[31:8];

    // Decode, accept logic, read/modify value and next-state selection.
    always_comb begin
        fl_in   = fp_flags_valid ? fp_flags : 5'd0;
        // Flags arriving this cycle are part of the "old" value a read sees.
        fl_cur  = fflags_q | fl_in;
        is_ff   = (csr_req_addr == 12'h001);
        is_rm   = (csr_req_addr == 12'h002);
        is_cs   = (csr_req_addr == 12'h003);
        legal   = is_ff | is_rm | is_cs;
        opnd    = csr_req_wdata[7:0];

        // Flag reads must wait for in-flight ops; frm accesses never do.
        stall     = STALL_ON_FP_BUSY && fp_busy && (is_ff || is_cs);
        req_ready = rst && (!resp_valid_q || csr_resp_ready) && !stall;
        accept    = csr_req_valid && req_ready;

        old_val = 8'd0;
        if (is_ff) old_val = {3'b000, fl_cur};
        if (is_rm) old_val = {5'b00000, frm_q};
        if (is_cs) old_val = {frm_q, fl_cur};

        case (csr_req_op)
            OP_RW:   new_val = opnd;
            OP_RS:   new_val = old_val | opnd;
            OP_RC:   new_val = old_val & ~opnd;
            default: new_val = old_val;
        endcase

        do_wr = accept && legal && (csr_req_op != 2'b00);

        fflags_d = fl_cur;
        frm_d    = frm_q;
        if (do_wr) begin
            // Re-OR this cycle's flags so a write can never drop them.
            if (is_ff) fflags_d = new_val[4:0] | fl_in;
            if (is_rm) frm_d    = new_val[2:0];
            if (is_cs) begin
                frm_d    = new_val[7:5];
                fflags_d = new_val[4:0] | fl_in;
            end
        end

        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_illegal_d = resp_illegal_q;
        if (accept) begin
            resp_valid_d   = 1'b1;
            resp_rdata_d   = legal ? {24'd0, old_val} : 32'd0;
            resp_illegal_d = !legal;
        end else if (csr_resp_ready) begin
            resp_valid_d   = 1'b0;
        end
    end

    // State and response buffer registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fflags_q       <= 5'd0;
            frm_q          <= RESET_FRM;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'd0;
            resp_illegal_q <= 1'b0;
        end else begin
            fflags_q       <= fflags_d;
            frm_q          <= frm_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end

    assign csr_req_ready    = req_ready;
    assign csr_resp_valid   = resp_valid_q;
    assign csr_resp_rdata   = resp_rdata_q;
    assign csr_resp_illegal = resp_illegal_q;
    assign frm              = frm_q;
    assign frm_invalid      = (frm_q == 3'b101) || (frm_q == 3'b110) || (frm_q == 3'b111);

endmodule

// File: tb/tb_rv32f_csr_responder.sv
// Directed bench for rv32f_csr_responder.
module tb_rv32f_csr_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic [11:0] csr_req_addr;
    logic [1:0]  csr_req_op;
    logic [31:0] csr_req_wdata;
    logic        csr_resp_valid;
    logic        csr_resp_ready;
    logic [31:0] csr_resp_rdata;
    logic        csr_resp_illegal;
    logic        fp_flags_valid;
    logic [4:0]  fp_flags;
    logic        fp_busy;
    logic [2:0]  frm;
    logic        frm_invalid;

    int errors = 0;
    int checks = 0;

    rv32f_csr_responder dut (
        .clk              (clk),
        .rst              (rst),
        .csr_req_valid    (csr_req_valid),
        .csr_req_ready    (csr_req_ready),
        .csr_req_addr     (csr_req_addr),
        .csr_req_op       (csr_req_op),
        .csr_req_wdata    (csr_req_wdata),
        .csr_resp_valid   (csr_resp_valid),
        .csr_resp_ready   (csr_resp_ready),
        .csr_resp_rdata   (csr_resp_rdata),
        .csr_resp_illegal (csr_resp_illegal),
        .fp_flags_valid   (fp_flags_valid),
        .fp_flags         (fp_flags),
        .fp_busy          (fp_busy),
        .frm              (frm),
        .frm_invalid      (frm_invalid)
    );

    always #5 clk = ~clk;

    // Drive one request and hold it until accepted (bounded); returns 1 # after
    // the accepting edge with the request dropped.
    task automatic send(input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] d, output bit ok);
        ok = 1'b0;
        csr_req_valid = 1'b1;
        csr_req_addr  = a;
        csr_req_op    = op;
        csr_req_wdata = d;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (csr_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        csr_req_valid = 1'b1; csr_req_addr = 12'h002; csr_req_op = 2'b01; csr_req_wdata = 32'h5;
        csr_resp_ready = 1'b1; fp_flags_valid = 1'b0; fp_flags = 5'd0; fp_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (csr_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", csr_req_ready); end
        checks++; if (csr_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", csr_resp_valid); end
        checks++; if (csr_resp_rdata !== 32'd0 || csr_resp_illegal !== 1'b0) begin errors++; $display("FAIL reset_resp got=%h/%b exp=0/0", csr_resp_rdata, csr_resp_illegal); end
        checks++; if (frm !== 3'd0 || frm_invalid !== 1'b0) begin errors++; $display("FAIL reset_frm got=%0d/%b exp=0/0", frm, frm_invalid); end
        csr_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_read_fcsr;
        bit ok;
        send(12'h003, 2'b00, 32'h0, ok);
        checks++; if (!ok || csr_resp_valid !== 1'b1) begin errors++; $display("FAIL read_fcsr_latency ok=%b valid=%b exp=1/1", ok, csr_resp_valid); end
        checks++; if (csr_resp_rdata !== 32'h0 || csr_resp_illegal !== 1'b0 || frm !== 3'd0) begin errors++; $display("FAIL read_fcsr got=%h/%b frm=%0d exp=0/0/0", csr_resp_rdata, csr_resp_illegal, frm); end
    endtask

    task automatic test_frm_write;
        bit ok;
        send(12'h002, 2'b01, 32'h3, ok);
        checks++; if (!ok || csr_resp_rdata !== 32'h0) begin errors++; $display("FAIL frm_rw_old got=%h exp=0", csr_resp_rdata); end
        checks++; if (frm !== 3'd3) begin errors++; $display("FAIL frm_after_edge got=%0d exp=3", frm); end
        send(12'h003, 2'b00, 32'h0, ok);
        checks++; if (!ok || csr_resp_rdata !== 32'h60) begin errors++; $display("FAIL fcsr_after_frm got=%h exp=60", csr_resp_rdata); end
    endtask

    task automatic test_flags;
        bit ok;
        fp_flags_valid = 1'b1; fp_flags = 5'b00001;
        @(posedge clk); #1;
        fp_flags = 5'b10000;
        @(posedge clk); #1;
        fp_flags_valid = 1'b0; fp_flags = 5'd0;
        send(12'h001, 2'b11, 32'h1, ok);
        checks++; if (!ok || csr_resp_rdata !== 32'h11) begin errors++; $display("FAIL flags_rc_old got=%h exp=11", csr_resp_rdata); end
        send(12'h001, 2'b00, 32'h0, ok);
        checks++; if (!ok || csr_resp_rdata !== 32'h10) begin errors++; $display("FAIL flags_after_rc got=%h exp=10", csr_resp_rdata); end
    endtask

    task automatic test_simul_write;
        bit ok;
        fp_flags_valid = 1'b1; fp_flags = 5'b00010;
        send(12'h001, 2'b01, 32'h4, ok);
        fp_flags_valid = 1'b0; fp_flags = 5'd0;
        checks++; if (!ok || csr_resp_rdata !== 32'h12) begin errors++; $display("FAIL simul_old got=%h exp=12", csr_resp_rdata); end
        send(12'h001, 2'b00, 32'h0, ok);
        checks++; if (!ok || csr_resp_rdata !== 32'h06) begin errors++; $display("FAIL simul_new got=%h exp=06", csr_resp_rdata); end
    endtask

    task automatic test_stall;
        bit ok;
        @(posedge clk); #1;
        fp_busy = 1'b1;
        csr_req_valid = 1'b1; csr_req_addr = 12'h001; csr_req_op = 2'b00; csr_req_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (csr_req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, csr_req_ready); end
        end
        @(posedge clk); #1;
        checks++; if (csr_resp_valid !== 1'b0) begin errors++; $display("FAIL stall_no_resp got=%b exp=0", csr_resp_valid); end
        fp_busy = 1'b0;
        @(negedge clk);
        checks++; if (csr_req_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", csr_req_ready); end
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
        checks++; if (csr_resp_valid !== 1'b1 || csr_resp_rdata !== 32'h06) begin errors++; $display("FAIL stall_resp got=%b/%h exp=1/06", csr_resp_valid, csr_resp_rdata); end
        fp_busy = 1'b1;
        send(12'h002, 2'b00, 32'h0, ok);
        checks++; if (!ok || csr_resp_rdata !== 32'h3) begin errors++; $display("FAIL frm_no_stall ok=%b got=%h exp=1/3", ok, csr_resp_rdata); end
        fp_busy = 1'b0;
    endtask

    task automatic test_back_to_back;
        int nresp;
        csr_resp_ready = 1'b0;
        csr_req_valid = 1'b1; csr_req_addr = 12'h002; csr_req_op = 2'b00; csr_req_wdata = 32'h0;
        @(posedge clk); #1;
        // Second request waits behind the held response.
        csr_req_addr = 12'h300; csr_req_op = 2'b01; csr_req_wdata = 32'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (csr_resp_valid !== 1'b1 || csr_resp_rdata !== 32'h3 || csr_resp_illegal !== 1'b0) begin errors++; $display("FAIL b2b_hold cyc=%0d got=%b/%h/%b exp=1/3/0", i, csr_resp_valid, csr_resp_rdata, csr_resp_illegal); end
            checks++; if (csr_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=0", i, csr_req_ready); end
            @(posedge clk); #1;
        end
        csr_resp_ready = 1'b1;
        nresp = 1;
        @(posedge clk); #1;
        csr_req_addr = 12'h002; csr_req_op = 2'b01; csr_req_wdata = 32'h7;
        checks++; if (csr_resp_valid !== 1'b1 || csr_resp_illegal !== 1'b1 || csr_resp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_illegal got=%b/%b/%h exp=1/1/0", csr_resp_valid, csr_resp_illegal, csr_resp_rdata); end
        if (csr_resp_valid) nresp++;
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
        checks++; if (csr_resp_rdata !== 32'h3 || csr_resp_illegal !== 1'b0) begin errors++; $display("FAIL b2b_frm_old got=%h/%b exp=3/0", csr_resp_rdata, csr_resp_illegal); end
        checks++; if (frm !== 3'd7 || frm_invalid !== 1'b1) begin errors++; $display("FAIL b2b_frm_invalid got=%0d/%b exp=7/1", frm, frm_invalid); end
        if (csr_resp_valid) nresp++;
        @(posedge clk); #1;
        checks++; if (csr_resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", csr_resp_valid); end
        checks++; if (nresp !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", nresp); end
    endtask

    task automatic test_fcsr_write;
        bit ok;
        // frm=7, fflags=6: clear frm bits via fcsr.
        send(12'h003, 2'b11, 32'hE0, ok);
        checks++; if (!ok || csr_resp_rdata !== 32'hE6) begin errors++; $display("FAIL fcsr_rc_old got=%h exp=e6", csr_resp_rdata); end
        checks++; if (frm !== 3'd0 || frm_invalid !== 1'b0) begin errors++; $display("FAIL fcsr_rc_frm got=%0d/%b exp=0/0", frm, frm_invalid); end
        // Upper operand bits are ignored.
        send(12'h003, 2'b01, 32'hFFFFFF2B, ok);
        send(12'h003, 2'b10, 32'h0, ok);
        checks++; if (!ok || csr_resp_rdata !== 32'h2B) begin errors++; $display("FAIL fcsr_rw_trunc got=%h exp=2b", csr_resp_rdata); end
        checks++; if (frm !== 3'd1) begin errors++; $display("FAIL fcsr_rw_frm got=%0d exp=1", frm); end
    endtask

    task automatic test_reset_drop;
        // Response pending and request asserted when reset hits.
        csr_resp_ready = 1'b0;
        csr_req_valid = 1'b1; csr_req_addr = 12'h002; csr_req_op = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
        checks++; if (csr_resp_valid !== 1'b0 || csr_resp_rdata !== 32'd0 || frm !== 3'd0) begin errors++; $display("FAIL reset_drop got=%b/%h/%0d exp=0/0/0", csr_resp_valid, csr_resp_rdata, frm); end
        rst = 1'b1; csr_resp_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_read_fcsr();
        test_frm_write();
        test_flags();
        test_simul_write();
        test_stall();
        test_back_to_back();
        test_fcsr_write();
        test_reset_drop();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
